// File: rtl/enc_snapshot_seq_pkg.sv
// enc_snapshot_seq_pkg: encoder read-address constants, field-offset table and sequencer states
package enc_snapshot_seq_pkg;

    localparam logic [3:0] ADDR_MAIN     = 4'h2;
    localparam logic [3:0] OFF_ENC_DATA  = 4'h0;
    localparam logic [3:0] OFF_PER_DATA  = 4'h4;
    localparam logic [3:0] OFF_QTR1_DATA = 4'h8;
    localparam logic [3:0] OFF_QTR5_DATA = 4'h9;
    localparam logic [3:0] OFF_RUN_DATA  = 4'hC;
    localparam logic [2:0] LAST_FIELD    = 3'd4;

    typedef enum logic [1:0] {IDLE, ARM, SCAN, SWAP} state_e;

    function automatic logic [3:0] field_off(input logic [2:0] f);
        return f == 3'd0 ? OFF_ENC_DATA  :
               f == 3'd1 ? OFF_PER_DATA  :
               f == 3'd2 ? OFF_QTR1_DATA :
               f == 3'd3 ? OFF_QTR5_DATA : OFF_RUN_DATA;
    endfunction

endpackage

// File: rtl/enc_snapshot_seq_dpram.sv
// snap_dpram: two-bank 16x8x32 simple dual-port snapshot RAM with a registered, gated read port
module snap_dpram (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        we_i,
    input  logic        wbank_i,
    input  logic [3:0]  wch_i,
    input  logic [2:0]  wfld_i,
    input  logic [31:0] wdata_i,
    input  logic        rbank_i,
    input  logic [3:0]  rch_i,
    input  logic [2:0]  rfld_i,
    input  logic        rok_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [2][16][8];
    logic [31:0] rdata_q;

    // Sequencer write port; array contents are intentionally left unreset
    always_ff @(posedge sysclk)
        if (we_i) mem_q[wbank_i][wch_i][wfld_i] <= wdata_i;

    // Registered host read; entries the top rejects read back as zero
    always_ff @(posedge sysclk)
        rdata_q <= !reset ? '0 : (rok_i ? mem_q[rbank_i][rch_i][rfld_i] : '0);

    assign rdata_o = rdata_q;

endmodule

// File: rtl/enc_snapshot_seq.sv
// enc_snapshot_seq: encoder snapshot sequencer/arbiter; SNAP_TIMESTAMP_EN adds a timestamp at entry 8'h00
module enc_snapshot_seq
    import enc_snapshot_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int STALL_MAX = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        snap_req,
    input  logic        snap_clr,
    output logic        snap_busy,
    output logic        snap_done,
    output logic        snap_valid,
    output logic        snap_ovr,
    output logic [7:0]  snap_seq,
    input  logic        host_ren,
    input  logic [15:0] host_raddr,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic [15:0] enc_raddr,
    input  logic [31:0] enc_rdata,
    input  logic [7:0]  buf_raddr,
    output logic [31:0] buf_rdata
);

    localparam logic [3:0] CH_LAST   = 4'(NUM_CH);
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    state_e      state_q;
    logic [3:0]  ch_q;
    logic [2:0]  fld_q;
    logic [7:0]  stall_q;
    logic        bank_q, done_q, valid_q, ovr_q;
    logic [7:0]  seq_q;
    logic        scan, seq_win, last_slot;
    logic [15:0] slot_addr;
    logic        we, ts_hit, rd_ok;
    logic [3:0]  wch, rd_ch, rd_fld;
    logic [2:0]  wfld;
    logic [31:0] wdata;

    assign scan      = state_q == SCAN;
    assign host_gnt  = host_ren & ~(scan & (stall_q >= STALL_LIM));
    assign seq_win   = scan & ~host_gnt;
    assign last_slot = ch_q == CH_LAST && fld_q == LAST_FIELD;
    assign slot_addr = {ADDR_MAIN, 4'h0, ch_q, field_off(fld_q)};
    assign enc_raddr = host_gnt ? host_raddr : (scan ? slot_addr : 16'h0);
    assign host_rdata = enc_rdata;

    // Snapshot FSM with slot walk, host-stall counter and published status
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= 4'd0;
            fld_q   <= 3'd0;
            stall_q <= 8'd0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            seq_q   <= 8'd0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= (snap_req && state_q != IDLE) | (ovr_q & ~snap_clr);
            case (state_q)
                IDLE: if (snap_req) state_q <= ARM;
                ARM: begin
                    ch_q    <= 4'd1;
                    fld_q   <= 3'd0;
                    stall_q <= 8'd0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    if (seq_win) begin
                        stall_q <= 8'd0;
                        if (last_slot) state_q <= SWAP;
                        else if (fld_q == LAST_FIELD) begin
                            fld_q <= 3'd0;
                            ch_q  <= ch_q + 4'd1;
                        end else fld_q <= fld_q + 3'd1;
                    end else stall_q <= stall_q + 8'd1;
                end
                SWAP: begin
                    bank_q  <= ~bank_q;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    seq_q   <= seq_q + 8'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running sysclk counter sampled into the back bank during ARM
    always_ff @(posedge sysclk)
        ts_q <= !reset ? 32'd0 : ts_q + 32'd1;

    // Back-bank write mux: timestamp in ARM, captured encoder data on won SCAN cycles
    always_comb begin
        we     = reset & (seq_win | state_q == ARM);
        wch    = state_q == ARM ? 4'd0 : ch_q;
        wfld   = state_q == ARM ? 3'd0 : fld_q;
        wdata  = state_q == ARM ? ts_q : enc_rdata;
        ts_hit = buf_raddr == 8'h00;
    end
`else
    // Back-bank write port driven only by won SCAN cycles
    always_comb begin
        we     = reset & seq_win;
        wch    = ch_q;
        wfld   = fld_q;
        wdata  = enc_rdata;
        ts_hit = 1'b0;
    end
`endif

    assign rd_ch  = buf_raddr[7:4];
    assign rd_fld = buf_raddr[3:0];
    assign rd_ok  = valid_q & ((rd_ch != 4'd0 && rd_ch <= CH_LAST && rd_fld <= 4'd4) | ts_hit);

    snap_dpram u_ram (
        .sysclk  (sysclk),
        .reset   (reset),
        .we_i    (we),
        .wbank_i (~bank_q),
        .wch_i   (wch),
        .wfld_i  (wfld),
        .wdata_i (wdata),
        .rbank_i (bank_q),
        .rch_i   (rd_ch),
        .rfld_i  (rd_fld[2:0]),
        .rok_i   (rd_ok),
        .rdata_o (buf_rdata)
    );

    assign snap_busy  = state_q != IDLE;
    assign snap_done  = done_q;
    assign snap_valid = valid_q;
    assign snap_ovr   = ovr_q;
    assign snap_seq   = seq_q;

endmodule

// File: tb/tb_enc_snapshot_seq.sv
// tb_enc_snapshot_seq: directed, table-driven self-checking bench for enc_snapshot_seq
module tb_enc_snapshot_seq;

    logic        sysclk, reset, snap_req, snap_clr, host_ren;
    logic        snap_busy, snap_done, snap_valid, snap_ovr, host_gnt;
    logic [7:0]  snap_seq, buf_raddr, gen;
    logic [15:0] host_raddr, enc_raddr;
    logic [31:0] host_rdata, enc_rdata, buf_rdata, ts_m, ts_exp;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [7:0]  raddr;
        int          kind;
        logic [15:0] lo;
    } vec_t;
    vec_t vecs[14];

    enc_snapshot_seq dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .snap_req   (snap_req),
        .snap_clr   (snap_clr),
        .snap_busy  (snap_busy),
        .snap_done  (snap_done),
        .snap_valid (snap_valid),
        .snap_ovr   (snap_ovr),
        .snap_seq   (snap_seq),
        .host_ren   (host_ren),
        .host_raddr (host_raddr),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .enc_raddr  (enc_raddr),
        .enc_rdata  (enc_rdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    assign enc_rdata = {8'hB0, gen, enc_raddr};

    always @(posedge sysclk) ts_m <= !reset ? 32'd0 : ts_m + 32'd1;

    function automatic logic [3:0] off_of(input int f);
        case (f)
            0:       return 4'h0;
            1:       return 4'h4;
            2:       return 4'h8;
            3:       return 4'h9;
            default: return 4'hC;
        endcase
    endfunction

    function automatic logic [31:0] entry(input logic [7:0] g, input int ch, input int f);
        return {8'hB0, g, 4'h2, 4'h0, 4'(ch), off_of(f)};
    endfunction

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_snap;
        snap_req = 1'b1;
        tick;
        snap_req = 1'b0;
        ts_exp = ts_m;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!snap_done && n < 400);
    endtask

    task automatic run_table(input string tag);
        logic [31:0] want, ts_want;
`ifdef SNAP_TIMESTAMP_EN
        ts_want = ts_exp;
`else
        ts_want = 32'd0;
`endif
        for (int i = 0; i < 14; i++) begin
            buf_raddr = vecs[i].raddr;
            tick;
            want = vecs[i].kind == 1 ? {8'hB0, gen, vecs[i].lo} : vecs[i].kind == 2 ? ts_want : 32'd0;
            chk($sformatf("%s_rd_%02h", tag, vecs[i].raddr), buf_rdata, want);
        end
    endtask

    initial begin
        int          n, bad_gnt, lost, bad_rd, dones;
        logic        want_gnt;
        logic [15:0] a1, a5;
        logic [31:0] hd1;

        vecs[0]  = '{8'h10, 1, 16'h2010};
        vecs[1]  = '{8'h14, 1, 16'h201C};
        vecs[2]  = '{8'h21, 1, 16'h2024};
        vecs[3]  = '{8'h23, 1, 16'h2029};
        vecs[4]  = '{8'h32, 1, 16'h2038};
        vecs[5]  = '{8'h40, 1, 16'h2040};
        vecs[6]  = '{8'h44, 1, 16'h204C};
        vecs[7]  = '{8'h50, 0, 16'h0000};
        vecs[8]  = '{8'h15, 0, 16'h0000};
        vecs[9]  = '{8'h1F, 0, 16'h0000};
        vecs[10] = '{8'h05, 0, 16'h0000};
        vecs[11] = '{8'hF0, 0, 16'h0000};
        vecs[12] = '{8'h47, 0, 16'h0000};
        vecs[13] = '{8'h00, 2, 16'h0000};

        reset = 1'b0; snap_req = 1'b0; snap_clr = 1'b0; host_ren = 1'b0;
        host_raddr = 16'h0; buf_raddr = 8'h23; gen = 8'h01; ts_exp = 32'd0;
        tick; tick;
        chk("rst_busy", snap_busy, 0);
        chk("rst_done", snap_done, 0);
        chk("rst_valid", snap_valid, 0);
        chk("rst_ovr", snap_ovr, 0);
        chk("rst_seq", snap_seq, 0);
        chk("rst_buf", buf_rdata, 0);
        chk("rst_enc_raddr", enc_raddr, 0);
        reset = 1'b1;
        tick;
        chk("pre_valid_buf", buf_rdata, 0);

        host_ren = 1'b1; host_raddr = 16'h1234; #1;
        chk("idle_gnt", host_gnt, 1);
        chk("idle_raddr", enc_raddr, 16'h1234);
        chk("idle_rdata", host_rdata, 32'hB001_1234);
        host_ren = 1'b0; #1;
        chk("idle_nogrant_raddr", enc_raddr, 0);

        // single snapshot, no host traffic
        start_snap;
        chk("t1_busy", snap_busy, 1);
        wait_done(n);
        chk("t1_latency", n, 22);
        chk("t1_busy_after", snap_busy, 0);
        chk("t1_seq", snap_seq, 1);
        chk("t1_valid", snap_valid, 1);
        tick;
        chk("t1_done_pulse", snap_done, 0);
        run_table("t1");

        // continuous host contention; buffer held at 8'h23 across the bank flip
        gen = 8'h02; host_ren = 1'b1; host_raddr = 16'h0ABC; buf_raddr = 8'h23;
        start_snap;
        n = 0; bad_gnt = 0; lost = 0; bad_rd = 0; a1 = 16'h0; a5 = 16'h0; hd1 = 32'h0;
        while (!snap_done && n < 400) begin
            tick;
            n++;
            if (n <= 100) begin
                want_gnt = ((n - 1) % 5) != 4;
                if (host_gnt !== want_gnt) bad_gnt++;
                if (!host_gnt) lost++;
            end
            if (n == 1) begin a1 = enc_raddr; hd1 = host_rdata; end
            if (n == 5) a5 = enc_raddr;
            if (buf_rdata !== entry(8'h01, 2, 3)) bad_rd++;
        end
        chk("t2_latency", n, 102);
        chk("t2_gnt_pattern_errs", bad_gnt, 0);
        chk("t2_seq_won", lost, 20);
        chk("t2_host_raddr", a1, 16'h0ABC);
        chk("t2_host_rdata", hd1, 32'hB002_0ABC);
        chk("t2_slot0_raddr", a5, 16'h2010);
        chk("t4_old_bank_errs", bad_rd, 0);
        tick;
        chk("t4_new_bank", buf_rdata, entry(8'h02, 2, 3));
        host_ren = 1'b0;
        for (int c = 1; c <= 4; c++)
            for (int f = 0; f < 5; f++) begin
                buf_raddr = {4'(c), 4'(f)};
                tick;
                chk($sformatf("t2_entry_%0d_%0d", c, f), buf_rdata, entry(8'h02, c, f));
            end
        chk("t2_seq", snap_seq, 2);

        // overrun handling
        gen = 8'h03;
        start_snap;
        tick; tick;
        snap_req = 1'b1;
        tick;
        snap_req = 1'b0;
        chk("t3_ovr_set", snap_ovr, 1);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (snap_done) dones++;
        end
        chk("t3_one_done", dones, 1);
        chk("t3_ovr_sticky", snap_ovr, 1);
        snap_clr = 1'b1;
        tick;
        snap_clr = 1'b0;
        chk("t3_ovr_clr", snap_ovr, 0);
        start_snap;
        snap_req = 1'b1; snap_clr = 1'b1;
        tick;
        snap_req = 1'b0; snap_clr = 1'b0;
        chk("t3_set_wins", snap_ovr, 1);
        wait_done(n);
        chk("t3_seq", snap_seq, 4);

        // reset while slot 10 is pending
        gen = 8'h05;
        start_snap;
        repeat (11) tick;
        chk("t5_busy_before", snap_busy, 1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("t5_busy", snap_busy, 0);
        chk("t5_valid", snap_valid, 0);
        chk("t5_buf", buf_rdata, 0);
        chk("t5_seq", snap_seq, 0);
        chk("t5_ovr", snap_ovr, 0);
        buf_raddr = 8'h23;
        tick;
        chk("t5_buf_invalid", buf_rdata, 0);
        chk("t5_no_done", snap_done, 0);
        start_snap;
        wait_done(n);
        chk("t5_latency", n, 22);
        chk("t5_seq_after", snap_seq, 1);
        run_table("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
